stopwatch_bcd_lap: RTL and testbench
====================================

// Module: stopwatch_bcd_lap
// PURPOSE
//  Parametrised multi-digit stopwatch: a prescaler generates a count tick, which drives a cascaded BCD
//  chain of 0.1 s / s / 10 s / min / 10 min / ... digits. Each digit gets its own registered
//  7-segment output. Adds run/stop, synchronous clear, overflow flag and an optional lap (display freeze).
//  Sits between the board clock and the 7-segment display pins of the timer front panel.
// PARAMETERS
//  TICK_DIV        5000000  clk cycles per 0.1 s tick (>=2); 5000000 = 50 MHz board
//  NUM_DIGITS      4        digit count, 3..8; d0=tenths, d1=s units, d2=s tens, d3+=minutes
//  SEG_ACTIVE_LOW  1        1: lit segment=0 (board LEDs); 0: invert all seg bits
// PORTS
//  clk        in   1              system clock
//  reset      in   1              synchronous, active-low reset
//  run        in   1              1 = count, 0 = hold (replaces old pause polarity)
//  clear      in   1              sync clear of count, prescaler and lap state
//  lap_req    in   1              single-cycle pulse: toggle lap freeze
//  seg        out  7*NUM_DIGITS   digit i at [7*i+6:7*i], bit order a(msb)..g(lsb)
//  bcd        out  4*NUM_DIGITS   live (unfrozen) count, digit i at [4*i+3:4*i]
//  lap_active out  1              1 while display frozen
//  ovf        out  1              one-cycle pulse on wrap from max to all-zero
// BEHAVIOUR
//  - Reset: prescaler=0, all digits=0, lap_active=0, ovf=0, seg = code for '0' on every digit
//    (active-low 7'b0000001), bcd=0. Reset is synchronous, active-low, clock clk.
//  - Priority per cycle: reset > clear > lap_req > tick. Clear makes reset-equal state except run is
//    untouched.
//  - Prescaler counts 0..TICK_DIV-1 only while run=1. tick = (run && presc==TICK_DIV-1); presc->0.
//    run=0 freezes presc at its current value (no loss of partial tick).
//  - Digit moduli: d0 10, d1 10, d2 6, d3..dN-1 10. Carry into digit k = tick && all lower digits at
//    max. Digit counters update on the tick edge, bcd is the counter registers (0 latency).
//  - Full-scale (all digits max) + tick -> all digits 0, ovf=1 for exactly that cycle; counting continues.
//  - seg is registered from the display source: 1 clk after bcd/latch change. Unknown codes (>9,
//    unreachable) decode to '0'.
//  - A clear during lap freeze releases the freeze and shows 0 next cycle.
// CONFIGURATION
//  STOPWATCH_LAP_EN defined: lap_req with lap_active=0 copies live digits into a display latch and sets
//    lap_active; lap_req with lap_active=1 clears it. While lap_active=1, seg shows the latch and the
//    live count keeps running. lap_req coinciding with a tick latches the pre-tick value.
//  Not defined: no latch; lap_req ignored; lap_active tied 0; seg always follows live count.
// STRUCTURE
//  stopwatch_pkg: SEG_* 7-bit digit codes (active-low base), function seg7_decode(bcd, active_low),
//    localparam DIGIT_MOD(k) lookup (10/10/6/10...).
//  Sub-module bcd_digit_cnt #(MOD): inputs clk, reset, clear, en; outputs q[3:0], at_max.
//    Instantiated NUM_DIGITS times via generate. Top holds the prescaler, carry chain, lap latch,
//    and seg registers.
// TESTING (sim with TICK_DIV=4, NUM_DIGITS=4, lap enabled unless noted)
//  1. reset=0 for 2 clk -> bcd=16'h0000, seg every digit 7'b0000001, lap_active=0, ovf=0.
//  2. run=1 for 40 clk -> bcd=16'h0010 (1.0 s); 600 ticks total -> bcd=16'h1000 (1:00.0).
//  3. run=1 for 2 clk, run=0 for 20 clk, run=1 -> d0 becomes 1 exactly 2 clk later (prescaler held).
//  4. Preload to 9:59.9 (16'h9599) via ticks, one more tick -> bcd=16'h0000, ovf=1 for one clk.
//  5. lap_req at 16'h0012, run 30 more ticks -> seg still shows 0:01.2, bcd=16'h0042; 2nd lap_req ->
//     seg shows 0:04.2 next clk, lap_active=0.
//  6. clear during lap freeze with run=1 -> next clk bcd=0, lap_active=0, presc restarts. Lap
//     disabled build: lap_req no effect.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the BCD stopwatch: 7-segment digit codes,
// the BCD-to-segment decoder and the per-digit modulus lookup.
// Segment bit order is a (msb) .. g (lsb); the base codes are active-low.
package stopwatch_pkg;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;

  // Decode one BCD digit; codes above 9 cannot occur and fall back to '0'.
  // With active_low cleared the whole pattern is inverted for active-high pins.
  function automatic logic [6:0] seg7_decode(input logic [3:0] bcd, input logic active_low);
    logic [6:0] code;
    case (bcd)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_0;
    endcase
    return active_low ? code : ~code;
  endfunction

  // Modulus of digit k: tenths and seconds units count to 10, seconds tens
  // to 6, every minute digit above that to 10.
  function automatic int DIGIT_MOD(input int k);
    return (k == 2) ? 6 : 10;
  endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// Single BCD digit counter with a configurable modulus. It advances on
// 'en' and wraps from MOD-1 back to zero; 'at_max' lets the parent build
// the carry chain without knowing each digit's modulus.
module bcd_digit_cnt #(
  parameter int MOD = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  output logic [3:0] q,
  output logic       at_max
);

  localparam logic [3:0] MAX_VAL = 4'(MOD - 1);

  logic [3:0] q_q;
  logic [3:0] q_d;

  assign at_max = (q_q == MAX_VAL);
  assign q      = q_q;

  // Next digit value: step when enabled, wrapping at the modulus.
  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = at_max ? 4'd0 : q_q + 4'd1;
    end
  end

  // Digit register; synchronous active-low reset, then clear, then count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q <= 4'd0;
    end else if (clear) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/stopwatch_bcd_lap.sv
// Multi-digit BCD stopwatch with registered 7-segment outputs.
// A prescaler turns the board clock into a 0.1 s tick that ripples through
// a chain of bcd_digit_cnt instances (tenths, s, 10 s, min, 10 min, ...).
// Optional lap freeze: define STOPWATCH_LAP_EN to hold the display on a
// latched copy of the count while the live count keeps running; without it
// lap_req is ignored and lap_active stays low.
module stopwatch_bcd_lap
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV       = 5000000,
  parameter int NUM_DIGITS     = 4,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    clear,
  input  logic                    lap_req,
  output logic [7*NUM_DIGITS-1:0] seg,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    lap_active,
  output logic                    ovf
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic          SEG_AL    = (SEG_ACTIVE_LOW != 0);
  localparam logic [6:0]    SEG_ZERO  = seg7_decode(4'd0, SEG_AL);

  logic [PW-1:0]           presc_q;
  logic [PW-1:0]           presc_d;
  logic                    tick;
  logic [NUM_DIGITS:0]     carry;
  logic [NUM_DIGITS-1:0]   digitAtMax;
  logic [4*NUM_DIGITS-1:0] liveBcd;
  logic [4*NUM_DIGITS-1:0] dispBcd;
  logic                    ovf_q;
  logic                    ovf_d;
  logic [7*NUM_DIGITS-1:0] seg_q;
  logic [7*NUM_DIGITS-1:0] seg_d;

  // The tick fires on the last prescaler count of a running period only,
  // so holding run low never loses a partially elapsed tenth.
  assign tick = run && (presc_q == PRESC_MAX);

  // Prescaler next state: advance while running, restart after a tick.
  always_comb begin
    presc_d = presc_q;
    if (run) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
  end

  // Prescaler register; clear restarts the partial tenth.
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q <= '0;
    end else if (clear) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // Carry into digit k is the tick gated by every lower digit sitting at max;
  // the carry out of the top digit marks the full-scale wrap.
  assign carry[0] = tick;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit_cnt #(
      .MOD(DIGIT_MOD(i))
    ) u_digit (
      .clk    (clk),
      .reset  (reset),
      .clear  (clear),
      .en     (carry[i]),
      .q      (liveBcd[4*i +: 4]),
      .at_max (digitAtMax[i])
    );
    assign carry[i+1] = carry[i] & digitAtMax[i];
  end

  assign ovf_d = carry[NUM_DIGITS];

  // Overflow pulse lines up with the cycle in which the digits read all-zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (clear) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic                    lap_q;
  logic                    lap_d;
  logic [4*NUM_DIGITS-1:0] latch_q;
  logic [4*NUM_DIGITS-1:0] latch_d;

  // A lap request toggles the freeze; entering it captures the pre-tick count.
  always_comb begin
    lap_d   = lap_q;
    latch_d = latch_q;
    if (lap_req) begin
      if (!lap_q) begin
        lap_d   = 1'b1;
        latch_d = liveBcd;
      end else begin
        lap_d = 1'b0;
      end
    end
  end

  // Lap state registers; clear drops the freeze along with the count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lap_q   <= 1'b0;
      latch_q <= '0;
    end else if (clear) begin
      lap_q   <= 1'b0;
      latch_q <= '0;
    end else begin
      lap_q   <= lap_d;
      latch_q <= latch_d;
    end
  end

  assign dispBcd    = lap_q ? latch_q : liveBcd;
  assign lap_active = lap_q;
`else
  logic lap_req_unused;

  assign lap_req_unused = lap_req;
  assign dispBcd        = liveBcd;
  assign lap_active     = 1'b0;
`endif

  // Segment patterns for every digit of whichever count is being displayed.
  always_comb begin
    seg_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      seg_d[7*i +: 7] = seg7_decode(dispBcd[4*i +: 4], SEG_AL);
    end
  end

  // Registered segment drivers; reset and clear both show '0' on every digit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      seg_q <= {NUM_DIGITS{SEG_ZERO}};
    end else if (clear) begin
      seg_q <= {NUM_DIGITS{SEG_ZERO}};
    end else begin
      seg_q <= seg_d;
    end
  end

  assign seg = seg_q;
  assign bcd = liveBcd;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_stopwatch_bcd_lap.sv
// Self-checking bench for stopwatch_bcd_lap (TICK_DIV=4, NUM_DIGITS=4).
// A reference model keeps the elapsed time as a plain count of tenths and
// derives digits and segment patterns arithmetically; directed steps add
// absolute expectations at the interesting points.
module tb_stopwatch_bcd_lap;

  localparam int TICK_DIV   = 4;
  localparam int NUM_DIGITS = 4;
  localparam int FULL       = 6000;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic                    clk     = 1'b0;
  logic                    reset   = 1'b0;
  logic                    run     = 1'b0;
  logic                    clear   = 1'b0;
  logic                    lap_req = 1'b0;
  logic [7*NUM_DIGITS-1:0] seg;
  logic [4*NUM_DIGITS-1:0] bcd;
  logic                    lap_active;
  logic                    ovf;

  int testCount = 0;
  int failCount = 0;

  int mPresc   = 0;
  int mCount   = 0;
  int mLatch   = 0;
  int mSegVal  = 0;
  bit mLap     = 1'b0;
  bit mOvf     = 1'b0;

  stopwatch_bcd_lap #(
    .TICK_DIV       (TICK_DIV),
    .NUM_DIGITS     (NUM_DIGITS),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .clear      (clear),
    .lap_req    (lap_req),
    .seg        (seg),
    .bcd        (bcd),
    .lap_active (lap_active),
    .ovf        (ovf)
  );

  // Free-running board clock.
  always #5 clk = ~clk;

  function automatic logic [6:0] segDigit(input int d);
    case (d)
      0:       return 7'b0000001;
      1:       return 7'b1001111;
      2:       return 7'b0010010;
      3:       return 7'b0000110;
      4:       return 7'b1001100;
      5:       return 7'b0100100;
      6:       return 7'b0100000;
      7:       return 7'b0001111;
      8:       return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction

  function automatic logic [15:0] bcdOf(input int t);
    return {4'((t / 600) % 10), 4'((t / 100) % 6), 4'((t / 10) % 10), 4'(t % 10)};
  endfunction

  function automatic logic [27:0] segOf(input int t);
    return {segDigit((t / 600) % 10), segDigit((t / 100) % 6),
            segDigit((t / 10) % 10), segDigit(t % 10)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic modelStep();
    bit tk;
    int segNext;
    if (!reset || clear) begin
      mPresc  = 0;
      mCount  = 0;
      mLatch  = 0;
      mLap    = 1'b0;
      mOvf    = 1'b0;
      mSegVal = 0;
    end else begin
      tk      = run && (mPresc == TICK_DIV - 1);
      segNext = mLap ? mLatch : mCount;
      if (lap_req && LAP_EN) begin
        if (!mLap) begin
          mLatch = mCount;
          mLap   = 1'b1;
        end else begin
          mLap = 1'b0;
        end
      end
      if (run) mPresc = tk ? 0 : mPresc + 1;
      mOvf = 1'b0;
      if (tk) begin
        mCount++;
        if (mCount == FULL) begin
          mCount = 0;
          mOvf   = 1'b1;
        end
      end
      mSegVal = segNext;
    end
  endtask

  task automatic checkModel();
    checkOutput("model_bcd", 32'(bcd), 32'(bcdOf(mCount)));
    checkOutput("model_seg", 32'(seg), 32'(segOf(mSegVal)));
    checkOutput("model_lap", 32'(lap_active), 32'(mLap));
    checkOutput("model_ovf", 32'(ovf), 32'(mOvf));
  endtask

  task automatic stepClock();
    modelStep();
    @(posedge clk);
    #1;
    checkModel();
  endtask

  task automatic applyStimulus(input logic r, input logic rn, input logic cl, input logic lr, input int n);
    reset   = r;
    run     = rn;
    clear   = cl;
    lap_req = lr;
    repeat (n) stepClock();
  endtask

  initial begin
    // Reset held for two clocks.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2);
    checkOutput("reset_bcd", 32'(bcd), 32'h0000);
    checkOutput("reset_seg", 32'(seg), 32'({4{7'b0000001}}));
    checkOutput("reset_lap", 32'(lap_active), 32'd0);
    checkOutput("reset_ovf", 32'(ovf), 32'd0);

    // Forty clocks make ten ticks, i.e. 1.0 s; 600 ticks make one minute.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 40);
    checkOutput("one_second", 32'(bcd), 32'h0010);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2360);
    checkOutput("one_minute", 32'(bcd), 32'h1000);

    // Held prescaler: the partial tenth survives a long stop.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1);
    checkOutput("clear_bcd", 32'(bcd), 32'h0000);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 20);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1);
    checkOutput("hold_one_clk", 32'(bcd), 32'h0000);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1);
    checkOutput("hold_two_clk", 32'(bcd), 32'h0001);

    // Full scale 9:59.9 then wrap with a single-cycle overflow pulse.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4 * (FULL - 1));
    checkOutput("full_scale", 32'(bcd), 32'h9599);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4);
    checkOutput("wrap_bcd", 32'(bcd), 32'h0000);
    checkOutput("wrap_ovf", 32'(ovf), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1);
    checkOutput("ovf_single", 32'(ovf), 32'd0);

    // Lap freeze at 0:01.2 while the live count runs on to 0:04.2.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 48);
    checkOutput("lap_start", 32'(bcd), 32'h0012);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1);
    checkOutput("lap_set", 32'(lap_active), 32'(LAP_EN));
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 119);
    checkOutput("lap_live", 32'(bcd), 32'h0042);
    checkOutput("lap_frozen_seg", 32'(seg), 32'(LAP_EN ? segOf(12) : segOf(41)));
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1);
    checkOutput("lap_release", 32'(lap_active), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1);
    checkOutput("lap_release_seg", 32'(seg), 32'(segOf(42)));

    // Clear during a freeze releases it and restarts the prescaler.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1);
    checkOutput("clr_lap_bcd", 32'(bcd), 32'h0000);
    checkOutput("clr_lap_active", 32'(lap_active), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3);
    checkOutput("clr_presc_hold", 32'(bcd), 32'h0000);
    checkOutput("clr_seg_zero", 32'(seg), 32'(segOf(0)));
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1);
    checkOutput("clr_presc_tick", 32'(bcd), 32'h0001);

    // Lap request on a tick cycle latches the pre-tick value.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1);
    checkOutput("lap_tick_bcd", 32'(bcd), 32'h0001);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1);
    checkOutput("lap_tick_seg", 32'(seg), 32'(LAP_EN ? segOf(0) : segOf(1)));

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(logic'($urandom_range(0, 499) != 0),
                    logic'($urandom_range(0, 9) != 0),
                    logic'($urandom_range(0, 199) == 0),
                    logic'($urandom_range(0, 19) == 0), 1);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
